// File: rtl/zcds3_stream_tx.sv
// CDS3 parallel-stream transmitter: pulls line payloads from a ping-pong RAM
// pair and regenerates PCLK, sync headers, payload bytes and blanking.
module zcds3_stream_tx #(
  parameter int CLK_DIV      = 3,
  parameter int LINE_BYTES   = 1024,
  parameter int FRAME_LINES  = 192,
  parameter int GAP_BYTES    = 16,
  parameter int PAYLOAD_BASE = 8
) (
  input  logic        iClk,
  input  logic        iRst_N,
  input  logic        iEn,
  output logic        oIR_PCLK,
  output logic [7:0]  oIR_Data,
  output logic        oRd_Which,
  output logic [13:0] oRd_Addr,
  output logic        oRd_En,
  input  logic [15:0] iRd_Data,
  input  logic [1:0]  iRAM_Data_Valid,
  output logic [1:0]  oRAM_Release,
  output logic        oTx_Frame_Start,
  output logic        oTx_Line_Done,
  output logic        oTx_Frame_Done,
  output logic        oUnderrun
);

  localparam logic [8:0]  SLOT_LAST = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0]  RISE_AT   = 9'(CLK_DIV - 1);
  localparam logic [15:0] PAY_LAST  = 16'(LINE_BYTES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_BYTES - 1);
  localparam logic [15:0] LAST_LINE = 16'(FRAME_LINES - 1);
  localparam logic [13:0] ADDR_BASE = 14'(PAYLOAD_BASE);

  typedef enum logic [2:0] {S_WAIT, S_FHDR, S_LHDR, S_PAY, S_GAP} state_t;

  // Frame header: three FF 00 00 xx groups with B6, AB, 9D tags.
  function automatic logic [7:0] frame_hdr_byte(input logic [15:0] idx);
    case (idx[3:0])
      4'd0, 4'd4, 4'd8: return 8'hFF;
      4'd3:             return 8'hB6;
      4'd7:             return 8'hAB;
      4'd11:            return 8'h9D;
      default:          return 8'h00;
    endcase
  endfunction

  state_t      r_state, w_nstate;
  logic [15:0] r_idx, w_nidx;
  logic [15:0] r_line, w_nline;
  logic [8:0]  r_cnt;
  logic        r_which, w_nwhich;
  logic [13:0] r_addr;
  logic        r_rd_en, r_cap;
  logic        r_pclk;
  logic [7:0]  r_data, w_nbyte;
  logic [15:0] r_hold;
  logic [1:0]  r_release, w_rel;
  logic        r_frame_start, r_line_done, r_frame_done, r_underrun;
  logic        w_fs, w_ld, w_fd, w_ur, w_strobe, w_addr_rst;
  logic        w_slot_end;

  assign w_slot_end = iEn && (r_cnt == SLOT_LAST);

  // FSM state register: the state/index describe the slot currently on the bus.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_state <= S_WAIT;
      r_idx   <= '0;
    end else if (w_slot_end) begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
    end
  end

  // Next-slot decode: state, byte to load, strobe and event pulses at slot end.
  always_comb begin
    w_nstate   = r_state;
    w_nidx     = r_idx + 16'd1;
    w_nline    = r_line;
    w_nwhich   = r_which;
    w_nbyte    = 8'h00;
    w_strobe   = 1'b0;
    w_addr_rst = 1'b0;
    w_rel      = 2'b00;
    w_fs       = 1'b0;
    w_ld       = 1'b0;
    w_fd       = 1'b0;
    w_ur       = 1'b0;
    case (r_state)
      S_WAIT: begin
        w_nidx     = '0;
        w_addr_rst = 1'b1;
        if (iRAM_Data_Valid[r_which]) begin
          if (r_line == '0) begin
            w_nstate = S_FHDR;
            w_fs     = 1'b1;
          end else begin
            w_nstate = S_LHDR;
          end
        end
      end
      S_FHDR: if (r_idx == 16'd11) begin w_nstate = S_LHDR; w_nidx = '0; end
      S_LHDR: if (r_idx == 16'd3)  begin w_nstate = S_PAY;  w_nidx = '0; end
      S_PAY: begin
        if (r_idx == PAY_LAST) begin
          w_nstate = S_GAP;
          w_nidx   = '0;
          w_ld     = 1'b1;
        end
      end
      S_GAP: begin
        if (r_idx == GAP_LAST) begin
          w_nstate       = S_WAIT;
          w_nidx         = '0;
          w_rel[r_which] = 1'b1;
          w_nwhich       = ~r_which;
          w_addr_rst     = 1'b1;
          if (r_line == LAST_LINE) begin
            w_fd    = 1'b1;
            w_nline = '0;
          end else begin
            w_nline = r_line + 16'd1;
          end
          w_ur = !iRAM_Data_Valid[w_nwhich] && (w_nline != '0);
        end
      end
      default: w_nstate = S_WAIT;
    endcase
    case (w_nstate)
      S_FHDR:  w_nbyte = frame_hdr_byte(w_nidx);
      S_LHDR:  w_nbyte = (w_nidx == 16'd0) ? 8'hFF : ((w_nidx == 16'd3) ? 8'h80 : 8'h00);
      S_PAY:   w_nbyte = w_nidx[0] ? r_hold[7:0] : r_hold[15:8];
      default: w_nbyte = 8'h00;
    endcase
    w_strobe = ((w_nstate == S_LHDR) && (w_nidx == 16'd3)) ||
               ((w_nstate == S_PAY) && w_nidx[0] && (w_nidx != PAY_LAST));
  end

  // Slot timer, PCLK, byte bus, read strobe/address, line counter and pulses.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      r_cnt         <= '0;
      r_pclk        <= 1'b0;
      r_data        <= 8'h00;
      r_which       <= 1'b0;
      r_addr        <= '0;
      r_rd_en       <= 1'b0;
      r_cap         <= 1'b0;
      r_line        <= '0;
      r_release     <= 2'b00;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_release     <= 2'b00;
      r_frame_start <= 1'b0;
      r_line_done   <= 1'b0;
      r_frame_done  <= 1'b0;
      r_underrun    <= 1'b0;
      if (iEn) begin
        r_cnt   <= w_slot_end ? 9'd0 : r_cnt + 9'd1;
        r_cap   <= r_rd_en;
        r_rd_en <= 1'b0;
        if (r_rd_en) r_addr <= r_addr + 14'd1;
        if (r_cnt == RISE_AT) r_pclk <= 1'b1;
        if (w_slot_end) begin
          r_pclk        <= 1'b0;
          r_data        <= w_nbyte;
          r_rd_en       <= w_strobe;
          r_which       <= w_nwhich;
          r_line        <= w_nline;
          r_release     <= w_rel;
          r_frame_start <= w_fs;
          r_line_done   <= w_ld;
          r_frame_done  <= w_fd;
          r_underrun    <= w_ur;
          if (w_addr_rst) r_addr <= ADDR_BASE;
        end
      end
    end
  end

  // Read data lands one cycle after the strobe is taken; hold it for the two byte slots.
  always_ff @(posedge iClk) begin
    if (iEn && r_cap) r_hold <= iRd_Data;
  end

  assign oIR_PCLK        = r_pclk;
  assign oIR_Data        = r_data;
  assign oRd_Which       = r_which;
  assign oRd_Addr        = r_addr;
  assign oRd_En          = r_rd_en;
  assign oRAM_Release    = r_release;
  assign oTx_Frame_Start = r_frame_start;
  assign oTx_Line_Done   = r_line_done;
  assign oTx_Frame_Done  = r_frame_done;
  assign oUnderrun       = r_underrun;

endmodule

// File: tb/tb_zcds3_stream_tx.sv
// Scoreboard bench for zcds3_stream_tx: expected bytes and read addresses are
// queued by the stimulus and popped by a negedge monitor.
module tb_zcds3_stream_tx;
  localparam int CLK_DIV = 3;
  localparam int LB      = 8;
  localparam int FL      = 4;
  localparam int GB      = 2;
  localparam int PB      = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] rd_data = 16'h0;
  logic [1:0]  valid = 2'b00;
  logic        pclk, which, rd_en, fs, ld, fd, ur;
  logic [7:0]  data;
  logic [13:0] addr;
  logic [1:0]  rel;

  always #5 clk = ~clk;

  zcds3_stream_tx #(.CLK_DIV(CLK_DIV), .LINE_BYTES(LB), .FRAME_LINES(FL),
                    .GAP_BYTES(GB), .PAYLOAD_BASE(PB)) dut (
    .iClk(clk), .iRst_N(rst_n), .iEn(en), .oIR_PCLK(pclk), .oIR_Data(data),
    .oRd_Which(which), .oRd_Addr(addr), .oRd_En(rd_en), .iRd_Data(rd_data),
    .iRAM_Data_Valid(valid), .oRAM_Release(rel), .oTx_Frame_Start(fs),
    .oTx_Line_Done(ld), .oTx_Frame_Done(fd), .oUnderrun(ur));

  logic [15:0] mem0 [0:16383];
  logic [15:0] mem1 [0:16383];

  // Single-port RAM pair with one-cycle read latency.
  always @(posedge clk) if (rd_en) rd_data <= which ? mem1[addr] : mem0[addr];

  int n_chk = 0, n_fail = 0;
  int n_pop = 0, n_pushed = 0;
  int n_fs = 0, n_ld = 0, n_fd = 0, n_ur = 0, n_rel0 = 0, n_rel1 = 0;
  bit chk = 1'b0;
  logic [7:0] exp_q[$];
  int exp_aq[$];
  int run = 0;
  logic last_pclk = 1'b0;
  logic [7:0] last_data = 8'h00;
  bit en_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int w, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (w == 0) return {kb, ~kb};
    return {8'hA0 + kb, 8'h30 ^ kb};
  endfunction

  task automatic push_b(input logic [7:0] b);
    exp_q.push_back(b);
    n_pushed++;
  endtask

  task automatic push_wait(input int n);
    for (int i = 0; i < n; i++) push_b(8'h00);
  endtask

  task automatic push_line(input int w, input bit first);
    logic [7:0] fh [12];
    logic [15:0] wd;
    fh = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'hFF, 8'h00, 8'h00, 8'hAB,
           8'hFF, 8'h00, 8'h00, 8'h9D};
    if (first) for (int i = 0; i < 12; i++) push_b(fh[i]);
    push_b(8'hFF); push_b(8'h00); push_b(8'h00); push_b(8'h80);
    for (int k = 0; k < LB / 2; k++) begin
      wd = word(w, k);
      push_b(wd[15:8]);
      push_b(wd[7:0]);
      exp_aq.push_back((w << 16) | (PB + k));
    end
    push_wait(GB);
  endtask

  task automatic wait_pops(input int target);
    int t;
    t = 0;
    while (n_pop < target && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (n_pop < target) check("timeout_pops", n_pop, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pclk"}, int'(pclk), 0);
    check({tag, "_data"}, int'(data), 0);
    check({tag, "_which"}, int'(which), 0);
    check({tag, "_addr"}, int'(addr), 0);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_release"}, int'(rel), 0);
    check({tag, "_pulses"}, int'({fs, ld, fd, ur}), 0);
  endtask

  // Monitor: byte per PCLK rise, PCLK widths, data-change alignment, strobes, pulses.
  always @(negedge clk) begin
    int e;
    if (!rst_n) run = 0;
    else if (en_prev) run++;
    if (chk && rst_n) begin
      if (pclk != last_pclk) check("pclk_width", run, CLK_DIV);
      if (pclk && !last_pclk) begin
        if (exp_q.size() == 0) check("byte_unexpected", int'(data), -1);
        else begin
          e = int'(exp_q.pop_front());
          check("byte", int'(data), e);
        end
        n_pop++;
      end
      if (data != last_data) check("data_change_at_fall", int'({last_pclk, pclk}), 2);
      if (rd_en && en) begin
        if (exp_aq.size() == 0) check("rd_unexpected", int'(addr), -1);
        else begin
          e = exp_aq.pop_front();
          check("rd_which_addr", (int'(which) << 16) | int'(addr), e);
        end
      end
      if (fs) begin
        n_fs++;
        check("frame_start_byte", int'(data), 8'hFF);
      end
      if (ld) n_ld++;
      if (fd) begin
        n_fd++;
        check("frame_done_lines", n_ld, FL * n_fd);
      end
      if (ur) n_ur++;
      if (rel[0]) n_rel0++;
      if (rel[1]) n_rel1++;
    end
    if (pclk != last_pclk) run = 0;
    last_pclk = pclk;
    last_data = data;
    en_prev = en && rst_n;
  end

  initial begin
    int tgt_ur, tgt_frz, tgt_rst, tgt_v;
    for (int k = 0; k < LB / 2; k++) begin
      mem0[PB + k] = word(0, k);
      mem1[PB + k] = word(1, k);
    end
    valid = 2'b01;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");

    // Frame 1: RAM1 not ready after line 0, then frame 2 lines 0 and 1.
    push_b(8'h00);
    push_line(0, 1'b1);
    push_wait(3);
    tgt_ur = n_pushed;
    push_line(1, 1'b0); push_wait(1);
    push_line(0, 1'b0); push_wait(1);
    push_line(1, 1'b0); push_wait(1);
    tgt_frz = n_pushed + 12 + 4 + 3;
    push_line(0, 1'b1); push_wait(1);
    tgt_rst = n_pushed + 4 + 5;
    push_line(1, 1'b0); push_wait(1);

    chk = 1'b1;
    rst_n = 1'b1;
    en = 1'b1;

    wait_pops(tgt_ur);
    #1 valid = 2'b11;
    check("underrun_count", n_ur, 1);

    wait_pops(tgt_frz);
    @(posedge clk);
    #1 en = 1'b0;
    repeat (37) @(posedge clk);
    #1 en = 1'b1;

    wait_pops(tgt_rst);
    @(posedge clk);
    #2 chk = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_outputs("midline_reset");
    check("cnt_line_done", n_ld, 5);
    check("cnt_frame_done", n_fd, 1);
    check("cnt_frame_start", n_fs, 2);
    check("cnt_release0", n_rel0, 3);
    check("cnt_release1", n_rel1, 2);
    exp_q.delete();
    exp_aq.delete();
    valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_pop = 0;
    n_pushed = 0;

    // Fresh frame after reset once RAM0 becomes valid.
    push_b(8'h00); push_b(8'h00);
    tgt_v = n_pushed;
    push_line(0, 1'b1); push_wait(1);
    push_line(1, 1'b0); push_wait(1);
    chk = 1'b1;
    rst_n = 1'b1;

    wait_pops(tgt_v);
    #1 valid = 2'b11;
    wait_pops(n_pushed);
    check("end_line_done", n_ld, 7);
    check("end_frame_start", n_fs, 3);
    check("end_release0", n_rel0, 4);
    check("end_release1", n_rel1, 3);
    check("end_underrun", n_ur, 1);
    check("end_byte_q_empty", exp_q.size(), 0);
    check("end_addr_q_empty", exp_aq.size(), 0);
    chk = 1'b0;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_chk++;
    n_fail++;
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
